ped_input_conditioner: RTL
==========================

// Module: ped_input_conditioner
// PURPOSE
//   Conditions the raw front-panel inputs of the intersection before they reach the traffic light controller.
//   Inputs: two pedestrian push-buttons and two mode switches (error, four-way stop).
//   Per input: 2-flop synchronisation, then a debounce state machine.
//   Buttons: emits a clean 1-cycle press pulse and a sticky pending request, held until the controller acks it.
//   Switches: emits debounced levels that drive the controller's error / four_way_stop inputs directly.
// PARAMETERS
//   DEBOUNCE_CYCLES  1_000_000  consecutive stable cycles required to accept a change (20 ms @ 50 MHz); must be >= 1
//   CNT_W            20         debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//   clk              in   1  system clock (50 MHz)
//   reset            in   1  synchronous, active-low reset
//   ns_btn_raw       in   1  NS pedestrian button, asynchronous, active-high, bouncy
//   ew_btn_raw       in   1  EW pedestrian button, asynchronous, active-high, bouncy
//   error_sw_raw     in   1  error switch, asynchronous, active-high
//   four_way_sw_raw  in   1  four-way-stop switch, asynchronous, active-high
//   ns_ack           in   1  controller has served the NS request; 1-cycle pulse
//   ew_ack           in   1  controller has served the EW request; 1-cycle pulse
//   ns_pedestrian    out  1  1-cycle pulse on each accepted NS press
//   ew_pedestrian    out  1  1-cycle pulse on each accepted EW press
//   ns_req_pending   out  1  sticky NS request; set by press, cleared by ns_ack
//   ew_req_pending   out  1  sticky EW request; set by press, cleared by ew_ack
//   error            out  1  debounced error switch level
//   four_way_stop    out  1  debounced four-way switch level
// BEHAVIOUR
//   - All state updates on posedge clk. reset==0 at an edge forces:
//       sync flops = 0; every channel FSM = LOW with cnt = 0; all outputs = 0.
//   - Synchroniser: s1 <= raw; s <= s1. The FSM consumes s only; raw inputs never touch logic directly.
//   - Per-channel FSM: LOW, PRESS_WAIT, HIGH, RELEASE_WAIT; cnt is CNT_W bits.
//       LOW:          s==1 -> PRESS_WAIT, cnt<=0.
//       PRESS_WAIT:   s==0 -> LOW (bounce rejected).
//                     cnt==DEBOUNCE_CYCLES-1 -> HIGH; level<=1; press pulse set.
//                     otherwise cnt<=cnt+1.
//       HIGH:         s==0 -> RELEASE_WAIT, cnt<=0.
//       RELEASE_WAIT: s==1 -> HIGH.
//                     cnt==DEBOUNCE_CYCLES-1 -> LOW; level<=0.
//                     otherwise cnt<=cnt+1.
//   - Latency: edge 0 is the first edge sampling raw at its new, stable value.
//       The registered output changes at edge DEBOUNCE_CYCLES+2 (D+2).
//       The same latency applies to release.
//   - Pulse outputs are registered.
//       High for exactly one cycle per LOW->HIGH acceptance.
//       Never asserted on a release; never asserted while held.
//   - Pending: set on the press pulse, cleared on ack.
//       Simultaneous press pulse and ack in one cycle -> pending stays 1 (press wins).
//       Ack while pending==0 is ignored.
//       A press while pending==1 still pulses; pending stays 1. No request counting.
//   - Glitch shorter than D stable cycles: no output change, no pulse. cnt restarts on every reversal.
//   - Input held high through reset: sync restarts at 0, so one press pulse fires D+2 edges after reset deasserts.
//   - Reset mid-debounce: the count is discarded; no pulse is emitted for the interrupted press.
//   - Channels are fully independent. Simultaneous presses on both buttons produce pulses in the same cycle.
// TESTING  (DEBOUNCE_CYCLES=4, CNT_W=3)
//   1. Reset held low 3 cycles, inputs 0 -> all outputs 0; release reset, inputs idle 20 cycles -> outputs stay 0.
//   2. ns_btn_raw 0->1 held -> ns_pedestrian=1 only in cycle after edge 6; ns_req_pending=1 from edge 6 onward.
//   3. ns_btn_raw toggles 1,0,1,0 each 2 cycles, then 0 -> no pulse, pending stays 0; then held 1 -> single pulse.
//   4. ns_req_pending=1, pulse ns_ack -> pending 0 next cycle.
//      New press pulse coincident with ack -> pending remains 1.
//   5. error_sw_raw 0->1 -> error=1 at edge 6; 1-cycle dip on raw -> error stays 1;
//      raw 1->0 held -> error=0 at edge 6.
//   6. ew_btn_raw high during reset, reset released -> ew_pedestrian pulse at edge 6 post-release.
//      Reset again mid-PRESS_WAIT -> no pulse, all outputs 0.

Source files
------------

// File: rtl/ped_input_conditioner.sv
// Front-panel input conditioner: two-flop synchronisers and debounce FSMs for two pedestrian
// buttons (press pulse + sticky request) and two mode switches (clean levels).
module ped_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic ns_btn_raw,
   input  logic ew_btn_raw,
   input  logic error_sw_raw,
   input  logic four_way_sw_raw,
   input  logic ns_ack,
   input  logic ew_ack,
   output logic ns_pedestrian,
   output logic ew_pedestrian,
   output logic ns_req_pending,
   output logic ew_req_pending,
   output logic error,
   output logic four_way_stop
);

   typedef enum logic [1:0] {
      ST_LOW          = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_HIGH         = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } deb_state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [3:0] raw_s;
   logic [1:0] ack_s;
   logic [1:0] pulse_s;
   logic [1:0] pending_s;
   logic [1:0] sw_level_s;

   // Channels 0/1 are the NS/EW buttons, 2/3 the error and four-way switches.
   assign raw_s = {four_way_sw_raw, error_sw_raw, ew_btn_raw, ns_btn_raw};
   assign ack_s = {ew_ack, ns_ack};

   for (genvar i = 0; i < 4; i++) begin : g_ch
      logic             sync1_r;
      logic             sync_r;
      deb_state_t       state_r;
      deb_state_t       state_next_s;
      logic [CNT_W-1:0] cnt_r;
      logic [CNT_W-1:0] cnt_next_s;
      logic             level_r;
      logic             level_next_s;

      // Two-flop synchroniser; only sync_r feeds the debounce logic.
      always_ff @(posedge clk) begin
         if (!reset) begin
            sync1_r <= 1'b0;
            sync_r  <= 1'b0;
         end else begin
            sync1_r <= raw_s[i];
            sync_r  <= sync1_r;
         end
      end

      // Debounce state and counter register.
      always_ff @(posedge clk) begin
         if (!reset) begin
            state_r <= ST_LOW;
            cnt_r   <= CNT_ZERO;
         end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
         end
      end

      // Next-state logic: any reversal during a wait abandons the count.
      always_comb begin
         state_next_s = state_r;
         cnt_next_s   = cnt_r;
         case (state_r)
            ST_LOW: begin
               if (sync_r) begin
                  state_next_s = ST_PRESS_WAIT;
                  cnt_next_s   = CNT_ZERO;
               end else begin
                  state_next_s = ST_LOW;
               end
            end
            ST_PRESS_WAIT: begin
               if (!sync_r) begin
                  state_next_s = ST_LOW;
               end else if (cnt_r == CNT_LAST) begin
                  state_next_s = ST_HIGH;
               end else begin
                  cnt_next_s = cnt_r + CNT_ONE;
               end
            end
            ST_HIGH: begin
               if (!sync_r) begin
                  state_next_s = ST_RELEASE_WAIT;
                  cnt_next_s   = CNT_ZERO;
               end else begin
                  state_next_s = ST_HIGH;
               end
            end
            ST_RELEASE_WAIT: begin
               if (sync_r) begin
                  state_next_s = ST_HIGH;
               end else if (cnt_r == CNT_LAST) begin
                  state_next_s = ST_LOW;
               end else begin
                  cnt_next_s = cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_next_s = ST_LOW;
               cnt_next_s   = CNT_ZERO;
            end
         endcase
      end

      // Output decode: the accepted level is high in HIGH and while a release is pending.
      always_comb begin
         level_next_s = (state_next_s == ST_HIGH) || (state_next_s == ST_RELEASE_WAIT);
      end

      // Registered debounced level.
      always_ff @(posedge clk) begin
         if (!reset) begin
            level_r <= 1'b0;
         end else begin
            level_r <= level_next_s;
         end
      end

      if (i < 2) begin : g_btn
         logic accept_s;
         logic pending_next_s;
         logic pulse_r;
         logic pending_r;

         // A press is accepted exactly when the level rises; a visible pulse also beats an ack.
         always_comb begin
            accept_s       = level_next_s & ~level_r;
            pending_next_s = accept_s | pulse_r | (pending_r & ~ack_s[i]);
         end

         // Registered press pulse and sticky request.
         always_ff @(posedge clk) begin
            if (!reset) begin
               pulse_r   <= 1'b0;
               pending_r <= 1'b0;
            end else begin
               pulse_r   <= accept_s;
               pending_r <= pending_next_s;
            end
         end

         assign pulse_s[i]   = pulse_r;
         assign pending_s[i] = pending_r;
      end else begin : g_sw
         assign sw_level_s[i-2] = level_r;
      end
   end

   assign ns_pedestrian  = pulse_s[0];
   assign ew_pedestrian  = pulse_s[1];
   assign ns_req_pending = pending_s[0];
   assign ew_req_pending = pending_s[1];
   assign error          = sw_level_s[0];
   assign four_way_stop  = sw_level_s[1];

endmodule
